// File: rtl/vs_led_pulse_drv.sv
// vs_led_pulse_drv: stretches single-cycle event strobes into CE-timed LED blinks with a queued replay
module vs_led_pulse_drv #(
  parameter int CNTR_WIDTH = 4,
  parameter int ON_LEN     = 8,
  parameter int OFF_LEN    = 4,
  parameter int PEND_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CE,
  input  logic                  EV_IN,
  input  logic                  CLR_OVF,
  output logic                  LED_OUT,
  output logic                  BUSY,
  output logic [PEND_WIDTH-1:0] PEND,
  output logic                  OVF
);
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t                  state, nxt;
  logic [CNTR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [PEND_WIDTH-1:0]   pend_nxt;
  logic                    on_end, gap_end, has, deq, inc, full, ovf_set;
  always_comb begin
    on_end   = CE && cnt == CNTR_WIDTH'(ON_LEN - 1);
    gap_end  = CE && cnt == CNTR_WIDTH'(OFF_LEN - 1);
    has      = PEND != '0;
    deq      = has && (state == IDLE || (state == GAP && gap_end));
    nxt      = state == IDLE ? (has ? ON : IDLE) :
               state == ON   ? (on_end ? GAP : ON) :
               gap_end       ? (has ? ON : IDLE) : GAP;
    // every phase change restarts the tick count
    cnt_nxt  = nxt != state ? '0 : (CE && state != IDLE) ? cnt + 1'b1 : cnt;
    full     = &PEND;
    inc      = EV_IN && !deq;
    ovf_set  = inc && full;
    pend_nxt = (inc && !full) ? PEND + 1'b1 : (deq && !EV_IN) ? PEND - 1'b1 : PEND;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      PEND    <= '0;
      LED_OUT <= 1'b0;
      BUSY    <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      PEND    <= pend_nxt;
      LED_OUT <= nxt == ON;
      BUSY    <= nxt != IDLE;
      OVF     <= ovf_set | (OVF & ~CLR_OVF);
    end
  end
endmodule

// File: tb/tb_vs_led_pulse_drv.sv
// tb_vs_led_pulse_drv: scoreboard bench for the LED pulse driver with ON_LEN=4, OFF_LEN=2, PEND_WIDTH=2
module tb_vs_led_pulse_drv;
  logic       CLK = 0, RST = 1, CE = 1, EV_IN = 0, CLR_OVF = 0;
  logic       LED_OUT, BUSY, OVF;
  logic [1:0] PEND;
  typedef struct packed {logic led; logic busy; logic [1:0] pend; logic ovf;} obs_t;
  obs_t exp_q[$], obs_q[$];
  int   n_vec = 0, n_err = 0;

  vs_led_pulse_drv #(.CNTR_WIDTH(4), .ON_LEN(4), .OFF_LEN(2), .PEND_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .EV_IN(EV_IN), .CLR_OVF(CLR_OVF),
    .LED_OUT(LED_OUT), .BUSY(BUSY), .PEND(PEND), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  function automatic obs_t now_obs();
    return '{led: LED_OUT, busy: BUSY, pend: PEND, ovf: OVF};
  endfunction

  // drive one cycle of inputs, record what the outputs must be after the edge, then what they are
  task automatic step(input logic ev, input logic ce, input logic clr, input obs_t e);
    EV_IN = ev; CE = ce; CLR_OVF = clr;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    obs_q.push_back(now_obs());
  endtask

  task automatic rst_pulse();
    EV_IN = 0; CE = 1; CLR_OVF = 0; RST = 1;
    @(posedge CLK); #1;
    RST = 0;
  endtask

  // CE every clock: pulse j occupies edges 1+6j..4+6j lit, then two gap edges; n pulses expected
  task automatic run_train(input logic [63:0] evm, input logic [63:0] clrm, input int n, input int edges);
    int   p = 0;
    logic o = 0, deq, set;
    obs_t e;
    for (int k = 0; k < edges; k++) begin
      deq = k >= 1 && (k - 1) % 6 == 0 && (k - 1) / 6 < n;
      set = evm[k] && !deq && p == 3;
      if (evm[k] && !deq && p < 3) p++;
      else if (!evm[k] && deq) p--;
      o = set ? 1'b1 : clrm[k] ? 1'b0 : o;
      e.led  = k >= 1 && (k - 1) / 6 < n && (k - 1) % 6 < 4;
      e.busy = k >= 1 && (k - 1) / 6 < n;
      e.pend = 2'(p);
      e.ovf  = o;
      step(evm[k], 1'b1, clrm[k], e);
    end
    EV_IN = 0; CLR_OVF = 0;
  endtask

  task automatic test_reset();
    obs_t y;
    #1;
    y = now_obs(); n_vec++;
    if (y !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_state: got %b want 00000", y);
    end
    EV_IN = 1;
    @(posedge CLK); #1;
    y = now_obs(); n_vec++;
    if (y !== obs_t'(0)) begin
      n_err++;
      $display("FAIL reset_hold: got %b want 00000", y);
    end
    EV_IN = 0; RST = 0;
  endtask

  task automatic test_single();
    rst_pulse();
    run_train(64'h1, 64'h0, 1, 10);
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), y = obs_q.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL single: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", y.led, y.busy, y.pend, y.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    rst_pulse();
    run_train(64'h7, 64'h0, 3, 21);
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), y = obs_q.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL back_to_back: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", y.led, y.busy, y.pend, y.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  // five events (one lost), then CLR_OVF racing another lost event, then a lone CLR_OVF
  task automatic test_overflow();
    rst_pulse();
    run_train(64'h3F, 64'h60, 4, 27);
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), y = obs_q.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL overflow: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", y.led, y.busy, y.pend, y.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  // PEND=3 when the GAP->ON dequeue at edge 7 coincides with a new event
  task automatic test_deq_collision();
    rst_pulse();
    run_train(64'h8F, 64'h0, 5, 33);
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), y = obs_q.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL deq_collision: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", y.led, y.busy, y.pend, y.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  task automatic test_ce_slow();
    rst_pulse();
    for (int k = 0; k < 28; k++)
      step(k == 0, k % 4 == 0, 1'b0, '{led: k >= 1 && k <= 15, busy: k >= 1 && k <= 23, pend: 2'(k == 0), ovf: 1'b0});
    for (int k = 0; k < 20; k++)
      step(k == 0, !(k >= 3 && k <= 12), 1'b0, '{led: k >= 1 && k <= 14, busy: k >= 1 && k <= 16, pend: 2'(k == 0), ovf: 1'b0});
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), y = obs_q.pop_front();
      n_vec++;
      if (y !== x) begin
        n_err++;
        $display("FAIL ce_gating: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", y.led, y.busy, y.pend, y.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  task automatic test_rst_mid_pulse();
    obs_t y;
    rst_pulse();
    run_train(64'h7, 64'h0, 3, 3);
    #2 RST = 1;
    #1 y = now_obs(); n_vec++;
    if (y !== obs_t'(0)) begin
      n_err++;
      $display("FAIL rst_abort: got %b want 00000", y);
    end
    #2 RST = 0;
    @(posedge CLK); #1;
    run_train(64'h0, 64'h0, 0, 16);
    run_train(64'h1, 64'h0, 1, 9);
    while (exp_q.size() != 0) begin
      obs_t x = exp_q.pop_front(), z = obs_q.pop_front();
      n_vec++;
      if (z !== x) begin
        n_err++;
        $display("FAIL rst_mid_pulse: got led=%b busy=%b pend=%0d ovf=%b want led=%b busy=%b pend=%0d ovf=%b", z.led, z.busy, z.pend, z.ovf, x.led, x.busy, x.pend, x.ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_deq_collision();
    test_ce_slow();
    test_rst_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
